// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide, one bit/cycle.
// Optional MULDIV_EARLY_OUT_EN lets trivially-known operations skip the iterative phase.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_md_i,
    output logic            ready_md_o,
    input  logic [2:0]      op_md_i,
    input  logic [XLEN-1:0] opr_a_md_i,
    input  logic [XLEN-1:0] opr_b_md_i,
    input  logic            kill_md_i,
    input  logic            res_ready_md_i,
    output logic            valid_md_o,
    output logic [XLEN-1:0] res_md_o,
    output logic            busy_md_o
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic                div0_q, div0_d, ovf_q, ovf_d;
    logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic                valid_q, valid_d;

    logic                accept, is_div_in, sa_in, sb_in, div0_in, ovf_in;
    logic [XLEN-1:0]     mag_a_in, mag_b_in;
    logic [2*XLEN-1:0]   acc_init;
    logic [XLEN:0]       mul_sum, rem_sh, diff;
    logic [2*XLEN-1:0]   mul_next, div_next, prod;
    logic [XLEN-1:0]     quo, rem, dividend, fix_res;

    assign accept    = valid_md_i & (state_q == StIdle) & ~kill_md_i;
    assign is_div_in = op_md_i[2];
    assign sa_in     = opr_a_md_i[XLEN-1] & ((op_md_i == 3'd1) || (op_md_i == 3'd2) ||
                                             (op_md_i == 3'd4) || (op_md_i == 3'd6));
    assign sb_in     = opr_b_md_i[XLEN-1] & ((op_md_i == 3'd1) || (op_md_i == 3'd4) ||
                                             (op_md_i == 3'd6));
    assign mag_a_in  = sa_in ? -opr_a_md_i : opr_a_md_i;
    assign mag_b_in  = sb_in ? -opr_b_md_i : opr_b_md_i;
    assign div0_in   = is_div_in & (opr_b_md_i == '0);
    assign ovf_in    = is_div_in & ~op_md_i[0] & (opr_b_md_i == '1) &
                       (opr_a_md_i == {1'b1, {(XLEN-1){1'b0}}});

`ifdef MULDIV_EARLY_OUT_EN
    logic mzero_in, lt_in, early_in;
    assign mzero_in = ~is_div_in & ((opr_a_md_i == '0) || (opr_b_md_i == '0));
    assign lt_in    = is_div_in & op_md_i[0] & (opr_a_md_i < opr_b_md_i);
    assign early_in = div0_in | ovf_in | mzero_in | lt_in;
`endif

    // Early-out operations preload the accumulator with their final datapath value.
    always_comb begin
        acc_init = is_div_in ? {{XLEN{1'b0}}, mag_a_in} : {{XLEN{1'b0}}, mag_b_in};
`ifdef MULDIV_EARLY_OUT_EN
        if (mzero_in) begin
            acc_init = '0;
        end else if (lt_in) begin
            acc_init = {opr_a_md_i, {XLEN{1'b0}}};
        end
`endif
    end

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring step: remainder in the upper half, quotient bits shift in at the bottom.
    assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign diff     = rem_sh - {1'b0, b_q};
    assign div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign prod     = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quo      = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem      = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    assign dividend = sign_a_q ? -a_q : a_q;

    always_comb begin
        fix_res = '0;
        case (op_q)
            3'd0:                fix_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fix_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fix_res = div0_q ? '1 : (ovf_q ? dividend : quo);
            default:             fix_res = div0_q ? dividend : (ovf_q ? '0 : rem);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        valid_d  = valid_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d     = op_md_i;
                    sign_a_d = sa_in;
                    sign_b_d = sb_in;
                    div0_d   = div0_in;
                    ovf_d    = ovf_in;
                    a_d      = mag_a_in;
                    b_d      = mag_b_in;
                    acc_d    = acc_init;
                    cnt_d    = CNT_W'(XLEN);
`ifdef MULDIV_EARLY_OUT_EN
                    state_d  = early_in ? StFixup : StCalc;
`else
                    state_d  = StCalc;
`endif
                end
            end
            StCalc: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StFixup;
                end
            end
            StFixup: begin
                res_d   = fix_res;
                valid_d = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                if (res_ready_md_i) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (kill_md_i) begin
            state_d = StIdle;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            valid_q  <= valid_d;
        end
    end

    assign ready_md_o = (state_q == StIdle);
    assign busy_md_o  = (state_q != StIdle);
    assign valid_md_o = valid_q;
    assign res_md_o   = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32); honours MULDIV_EARLY_OUT_EN for latency.
module tb_muldiv_unit;

    localparam int FULL_LAT = 34;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = 34;
`endif

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_md_i = 1'b0;
    logic [2:0]  op_md_i = '0;
    logic [31:0] opr_a_md_i = '0;
    logic [31:0] opr_b_md_i = '0;
    logic        kill_md_i = 1'b0;
    logic        res_ready_md_i = 1'b0;
    logic        ready_md_o, valid_md_o, busy_md_o;
    logic [31:0] res_md_o;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_md_i     (valid_md_i),
        .ready_md_o     (ready_md_o),
        .op_md_i        (op_md_i),
        .opr_a_md_i     (opr_a_md_i),
        .opr_b_md_i     (opr_b_md_i),
        .kill_md_i      (kill_md_i),
        .res_ready_md_i (res_ready_md_i),
        .valid_md_o     (valid_md_o),
        .res_md_o       (res_md_o),
        .busy_md_o      (busy_md_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive a request at a negedge; returns just after the accepting rising edge.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_md_i    = op;
        opr_a_md_i = a;
        opr_b_md_i = b;
        valid_md_i = 1'b1;
        @(posedge clk);
    endtask

    // lat = index (from the accept edge) of the rising edge at which valid is first seen high.
    // lat stays 0 if the result never shows up within the budget.
    task automatic wait_result(output logic [31:0] res, output int lat);
        lat = 0;
        res = 'x;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            valid_md_i = 1'b0;
            if (valid_md_o) begin
                lat = k + 1;
                res = res_md_o;
                break;
            end
        end
    endtask

    task automatic consume();
        res_ready_md_i = 1'b1;
        @(negedge clk);
        res_ready_md_i = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        start_op(op, a, b);
        wait_result(res, lat);
        consume();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (ready_md_o !== 1'b1) begin n_fail++;
            $display("FAIL reset_ready got %b want 1", ready_md_o); end
        n_checks++; if (busy_md_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy got %b want 0", busy_md_o); end
        n_checks++; if (valid_md_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid got %b want 0", valid_md_o); end
        n_checks++; if (res_md_o !== 32'h0) begin n_fail++;
            $display("FAIL reset_res got %h want 0", res_md_o); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        vec_t        v[6];
        logic [31:0] r;
        int          l;
        v[0] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        v[1] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        v[2] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        v[3] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        v[4] = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1};
        v[5] = '{3'd1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF};
        for (int i = 0; i < 6; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, r, l);
            n_checks++; if (r !== v[i].exp) begin n_fail++;
                $display("FAIL mul_res[%0d] got %h want %h", i, r, v[i].exp); end
            n_checks++; if (l !== FULL_LAT) begin n_fail++;
                $display("FAIL mul_lat[%0d] got %0d want %0d", i, l, FULL_LAT); end
        end
    endtask

    task automatic test_div();
        vec_t        v[6];
        logic [31:0] r;
        int          l;
        v[0] = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        v[1] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        v[2] = '{3'd5, 32'd100,       32'd7,         32'd14};
        v[3] = '{3'd7, 32'd100,       32'd7,         32'd2};
        v[4] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
        v[5] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1};
        for (int i = 0; i < 6; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, r, l);
            n_checks++; if (r !== v[i].exp) begin n_fail++;
                $display("FAIL div_res[%0d] got %h want %h", i, r, v[i].exp); end
            n_checks++; if (l !== FULL_LAT) begin n_fail++;
                $display("FAIL div_lat[%0d] got %0d want %0d", i, l, FULL_LAT); end
        end
    endtask

    task automatic test_special();
        vec_t        v[10];
        logic [31:0] r;
        int          l;
        v[0] = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF};
        v[1] = '{3'd6, 32'd5,         32'd0,         32'd5};
        v[2] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        v[3] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        v[4] = '{3'd5, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF};
        v[5] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
        v[6] = '{3'd5, 32'd3,         32'd10,        32'd0};
        v[7] = '{3'd7, 32'd3,         32'd10,        32'd3};
        v[8] = '{3'd0, 32'd0,         32'd1234,      32'd0};
        v[9] = '{3'd3, 32'hFFFF_FFFF, 32'd0,         32'd0};
        for (int i = 0; i < 10; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, r, l);
            n_checks++; if (r !== v[i].exp) begin n_fail++;
                $display("FAIL spec_res[%0d] got %h want %h", i, r, v[i].exp); end
            n_checks++; if (l !== EARLY_LAT) begin n_fail++;
                $display("FAIL spec_lat[%0d] got %0d want %0d", i, l, EARLY_LAT); end
        end
    endtask

    // Result held in DONE, then a request offered in the transfer cycle must wait a cycle.
    task automatic test_back_to_back();
        logic [31:0] r;
        int          l;
        start_op(3'd5, 32'd100, 32'd7);
        wait_result(r, l);
        n_checks++; if (r !== 32'd14) begin n_fail++;
            $display("FAIL hold_first got %h want %h", r, 32'd14); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++; if (valid_md_o !== 1'b1) begin n_fail++;
                $display("FAIL hold_valid[%0d] got %b want 1", i, valid_md_o); end
            n_checks++; if (res_md_o !== 32'd14) begin n_fail++;
                $display("FAIL hold_res[%0d] got %h want %h", i, res_md_o, 32'd14); end
            n_checks++; if (ready_md_o !== 1'b0) begin n_fail++;
                $display("FAIL hold_ready[%0d] got %b want 0", i, ready_md_o); end
        end
        res_ready_md_i = 1'b1;
        valid_md_i     = 1'b1;
        op_md_i        = 3'd0;
        opr_a_md_i     = 32'd7;
        opr_b_md_i     = 32'd6;
        @(negedge clk);
        res_ready_md_i = 1'b0;
        n_checks++; if (valid_md_o !== 1'b0) begin n_fail++;
            $display("FAIL xfer_valid got %b want 0", valid_md_o); end
        n_checks++; if (ready_md_o !== 1'b1) begin n_fail++;
            $display("FAIL xfer_ready got %b want 1", ready_md_o); end
        n_checks++; if (busy_md_o !== 1'b0) begin n_fail++;
            $display("FAIL xfer_no_bypass busy got %b want 0", busy_md_o); end
        @(posedge clk);
        wait_result(r, l);
        consume();
        n_checks++; if (r !== 32'd42) begin n_fail++;
            $display("FAIL b2b_res got %h want %h", r, 32'd42); end
        n_checks++; if (l !== FULL_LAT) begin n_fail++;
            $display("FAIL b2b_lat got %0d want %0d", l, FULL_LAT); end
    endtask

    task automatic test_kill();
        logic [31:0] r;
        int          l;
        logic        seen;
        // kill beats valid while idle
        @(negedge clk);
        valid_md_i = 1'b1;
        kill_md_i  = 1'b1;
        @(negedge clk);
        valid_md_i = 1'b0;
        kill_md_i  = 1'b0;
        n_checks++; if (busy_md_o !== 1'b0) begin n_fail++;
            $display("FAIL kill_idle busy got %b want 0", busy_md_o); end
        // kill during CALC cycle 10, with a competing request
        start_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) begin
            @(negedge clk);
            valid_md_i = 1'b0;
        end
        kill_md_i  = 1'b1;
        valid_md_i = 1'b1;
        opr_a_md_i = 32'd3;
        opr_b_md_i = 32'd5;
        @(negedge clk);
        kill_md_i  = 1'b0;
        valid_md_i = 1'b0;
        n_checks++; if (ready_md_o !== 1'b1) begin n_fail++;
            $display("FAIL kill_calc ready got %b want 1", ready_md_o); end
        n_checks++; if (busy_md_o !== 1'b0) begin n_fail++;
            $display("FAIL kill_calc busy got %b want 0", busy_md_o); end
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (valid_md_o || busy_md_o) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++;
            $display("FAIL kill_no_result got %b want 0", seen); end
        do_op(3'd3, 32'd3, 32'd5, r, l);
        n_checks++; if (r !== 32'd0) begin n_fail++;
            $display("FAIL post_kill_res got %h want 0", r); end
        n_checks++; if (l !== FULL_LAT) begin n_fail++;
            $display("FAIL post_kill_lat got %0d want %0d", l, FULL_LAT); end
        // kill beats res_ready in DONE
        start_op(3'd0, 32'd9, 32'd9);
        wait_result(r, l);
        kill_md_i      = 1'b1;
        res_ready_md_i = 1'b1;
        @(negedge clk);
        kill_md_i      = 1'b0;
        res_ready_md_i = 1'b0;
        n_checks++; if (valid_md_o !== 1'b0) begin n_fail++;
            $display("FAIL kill_done valid got %b want 0", valid_md_o); end
        n_checks++; if (ready_md_o !== 1'b1) begin n_fail++;
            $display("FAIL kill_done ready got %b want 1", ready_md_o); end
    endtask

    task automatic test_reset_done();
        logic [31:0] r;
        int          l;
        start_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result(r, l);
        n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++;
            $display("FAIL rst_done_pre got %h want %h", r, 32'hFFFF_FFFF); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (valid_md_o !== 1'b0) begin n_fail++;
            $display("FAIL rst_done_valid got %b want 0", valid_md_o); end
        n_checks++; if (res_md_o !== 32'h0) begin n_fail++;
            $display("FAIL rst_done_res got %h want 0", res_md_o); end
        n_checks++; if (ready_md_o !== 1'b1) begin n_fail++;
            $display("FAIL rst_done_ready got %b want 1", ready_md_o); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_kill();
        test_reset_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative, parametrised multiply/divide unit for the RV32M/RV64M extension. It sits in the EX stage beside the single-cycle ALU.
- It accepts one operation through a valid/ready handshake and computes one bit per cycle: shift-add for multiply, restoring division for divide.
- It holds the result until the pipeline accepts it. The pipeline stalls on busy_md_o and can flush an in-flight operation with kill_md_i.

Parameters:
- XLEN, 32, operand/result width; legal values 32 and 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_md_i  input  1  operation request.
- ready_md_o  output  1  unit can accept; high only in IDLE.
- op_md_i  input  3  funct3 code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- opr_a_md_i  input  XLEN  rs1 operand (multiplicand / dividend).
- opr_b_md_i  input  XLEN  rs2 operand (multiplier / divisor).
- kill_md_i  input  1  flush; abort any operation.
- res_ready_md_i  input  1  consumer accepts result.
- valid_md_o  output  1  res_md_o is valid.
- res_md_o  output  XLEN  result.
- busy_md_o  output  1  high in CALC, FIXUP and DONE.

Behaviour:
- Reset values: state IDLE, valid_md_o=0, res_md_o=0, counter=0, and all internal operand/accumulator registers 0. After reset, ready_md_o=1 and busy_md_o=0.
- States and transitions:
  - IDLE to CALC on accept, where accept = valid_md_i & ready_md_o & ~kill_md_i.
  - CALC to FIXUP when counter reaches 0.
  - FIXUP to DONE.
  - DONE to IDLE on res_ready_md_i.
- Capture (on accept):
  - Latch op. Record the signs of a and b per op: signed for MULH/DIV/REM, a only for MULHSU, none otherwise.
  - Store magnitudes (two's-complement negate when signed and negative). Set counter=XLEN.
- CALC:
  - Each cycle processes one bit and decrements the counter; exactly XLEN CALC cycles.
  - Multiply: a 2*XLEN accumulator, shift-right-add.
  - Divide: restoring, 2*XLEN remainder/quotient register, shift-left-subtract.
- FIXUP (one cycle): apply sign correction.
  - Product is negated if sign_a^sign_b.
  - Quotient is negated if sign_a^sign_b.
  - Remainder takes the sign of the dividend.
  - Result selection: MUL = low XLEN bits of product; MULH/MULHSU/MULHU = high XLEN bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - res_md_o and valid_md_o are registered at the FIXUP-to-DONE edge.
- Latency: accept at edge N gives valid_md_o high from edge N+XLEN+2, i.e. 34 cycles for XLEN=32.
- DONE: valid_md_o and res_md_o are held stable until res_ready_md_i. The cycle valid&res_ready are both high is the transfer; valid_md_o is 0 next cycle. A new request is accepted no earlier than the cycle after the transfer (no back-to-back bypass).
- Special cases (detected at capture, forced in FIXUP regardless of datapath):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (a = most-negative, b = -1): DIV gives a; REM gives 0.
- kill_md_i:
  - In any state, next state is IDLE and valid_md_o=0; a result in DONE is discarded.
  - kill has priority over valid_md_i in the same cycle (no accept).
  - kill has priority over res_ready_md_i.
- reset mid-operation: same effect as kill, plus res_md_o cleared to 0.
- Inputs other than kill/res_ready are ignored outside IDLE.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: operations known at capture skip CALC, going IDLE to FIXUP directly. valid_md_o is then high from edge N+2. These operations are:
  - divide-by-zero;
  - signed overflow;
  - multiply with either operand 0 (result 0);
  - DIVU/REMU with a < b (quotient 0, remainder a).
- Not defined: every operation takes the full XLEN+2 latency. Results are bit-identical either way.

Test Plan:
- XLEN=32, MULH a=0x80000000 b=0x80000000 -> res 0x40000000 at cycle 34; MUL same operands -> 0x00000000.
- MULHSU a=0xFFFFFFFF b=0xFFFFFFFF -> res 0xFFFFFFFF; MULHU same -> 0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9) b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIV b=0 a=5 -> 0xFFFFFFFF; REM -> 5; DIV a=0x80000000 b=-1 -> 0x80000000; REM -> 0. Latency is 2 with MULDIV_EARLY_OUT_EN, 34 without.
- Hold res_ready_md_i low 10 cycles in DONE -> valid/res stable, ready_md_o=0. Then pulse it -> valid drops next cycle and ready_md_o=1.
- Assert kill_md_i at CALC cycle 10 together with valid_md_i -> IDLE next cycle, no valid_md_o ever for that op. Then a new MULHU 3*5 -> res 0. Assert reset in DONE -> valid 0, res 0.
